// File: rtl/bram_responder.sv
// bram_responder: dual-port BRAM responder with one read and one write
// request per cycle, fixed read latency, saturating access counters and a
// sticky out-of-range flag.
//
// Read handshake: loadEn has no back-pressure. A request at edge N always
// produces exactly one result, loadValid=1 for one cycle with loadData,
// after edge N+READ_LATENCY-1. Results come back in request order. When no
// result arrives, loadValid=0 and loadData keeps its last value. A reset
// discards all results still in flight.
module bram_responder #(
    parameter int DATA_TYPE    = 32,
    parameter int ADDR_TYPE    = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loadEn,
    input  logic [ADDR_TYPE-1:0] loadAddr,
    output logic [DATA_TYPE-1:0] loadData,
    output logic                 loadValid,
    input  logic                 storeEn,
    input  logic [ADDR_TYPE-1:0] storeAddr,
    input  logic [DATA_TYPE-1:0] storeData,
    output logic [CNT_WIDTH-1:0] loadCount,
    output logic [CNT_WIDTH-1:0] storeCount,
    output logic                 addrErr
);

    // Array index width, and a compare width wide enough to hold both any
    // address and DEPTH. Addresses are zero-extended, so no aliasing.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = ((ADDR_TYPE > 32) ? ADDR_TYPE : 32) + 1;
    localparam logic [CW-1:0] DEPTH_EXT = CW'(DEPTH);

    logic [DATA_TYPE-1:0] mem [DEPTH];

    logic [CW-1:0]        loadAddrExt;
    logic [CW-1:0]        storeAddrExt;
    logic                 loadInRange;
    logic                 storeInRange;
    logic [DATA_TYPE-1:0] readWord;
    logic                 srcValid;
    logic [DATA_TYPE-1:0] srcData;

    // Range checks on the zero-extended addresses; an out-of-range read yields 0.
    always_comb begin
        loadAddrExt  = CW'(loadAddr);
        storeAddrExt = CW'(storeAddr);
        loadInRange  = loadAddrExt < DEPTH_EXT;
        storeInRange = storeAddrExt < DEPTH_EXT;
        readWord     = '0;
        if (loadInRange) begin
            readWord = mem[loadAddrExt[AW-1:0]];
        end
    end

    // Array write; contents are not reset. The read above sees the old word,
    // so a same-edge read and write to one address is read-first.
    always_ff @(posedge clk) begin
        if (!rst && storeEn && storeInRange) begin
            mem[storeAddrExt[AW-1:0]] <= storeData;
        end
    end

    generate
        if (READ_LATENCY <= 1) begin : gNoPipe
            // Latency 1: the sampled word goes straight into the output register.
            always_comb begin
                srcValid = loadEn;
                srcData  = readWord;
            end
        end else begin : gPipe
            logic [READ_LATENCY-2:0] pipeValid;
            logic [DATA_TYPE-1:0]    pipeData [READ_LATENCY-1];

            // Shift pipeline of {valid, data}; stage 0 samples the array.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipeValid <= '0;
                    for (int i = 0; i < READ_LATENCY - 1; i++) begin
                        pipeData[i] <= '0;
                    end
                end else begin
                    pipeValid[0] <= loadEn;
                    pipeData[0]  <= readWord;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        pipeValid[i] <= pipeValid[i-1];
                        pipeData[i]  <= pipeData[i-1];
                    end
                end
            end

            // The last internal stage feeds the output register.
            always_comb begin
                srcValid = pipeValid[READ_LATENCY-2];
                srcData  = pipeData[READ_LATENCY-2];
            end
        end
    endgenerate

    // Output register: strobe on a new result, hold the data otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadValid <= 1'b0;
            loadData  <= '0;
        end else begin
            loadValid <= srcValid;
            if (srcValid) begin
                loadData <= srcData;
            end
        end
    end

    // Saturating access counters and the sticky out-of-range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadCount  <= '0;
            storeCount <= '0;
            addrErr    <= 1'b0;
        end else begin
            if (loadEn && (loadCount != {CNT_WIDTH{1'b1}})) begin
                loadCount <= loadCount + 1'b1;
            end
            if (storeEn && (storeCount != {CNT_WIDTH{1'b1}})) begin
                storeCount <= storeCount + 1'b1;
            end
            if ((loadEn && !loadInRange) || (storeEn && !storeInRange)) begin
                addrErr <= 1'b1;
            end
        end
    end

endmodule
